// File: rtl/op_sequencer.sv
// op_sequencer: button-driven operand-entry and execute sequencer for the
// calculator datapath. Each accepted press of the active-low `next` button
// walks IDLE -> LOAD_A -> LOAD_B (skipped for unary ops) -> EXEC -> SHOW -> IDLE.
// The block drives the register-file write strobes, a timed ALU enable, the
// display select, a done flag and a state code for the status digit.
//
// Build option: define OP_SEQUENCER_DEBOUNCE_EN to add a level debouncer
// between the synchronizer and the press detector. DEBOUNCE_CYCLES is only
// used by that option.
module op_sequencer #(
    parameter int EXEC_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       next,
    input  logic [2:0] MS,
    output logic [2:0] ms_q,
    output logic       we,
    output logic       w1,
    output logic       alu_en,
    output logic [1:0] led_sel,
    output logic       done,
    output logic [3:0] cs_out
);

    // State encodings double as the status-digit code.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_SHOW   = 3'd4;

    // Display source codes.
    localparam logic [1:0] LED_BLANK  = 2'b00;
    localparam logic [1:0] LED_DIN    = 2'b01;
    localparam logic [1:0] LED_RESULT = 2'b10;

    // The EXEC counter counts down to zero, so it starts one below the length.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    // Ops 6 and 7 take a single operand and skip LOAD_B.
    localparam logic [2:0] FIRST_UNARY_OP = 3'd6;

    // Display source for each state; unreachable codes show blank.
    function automatic logic [1:0] led_for_state(input logic [2:0] st);
        logic [1:0] sel;
        case (st)
            S_LOAD_A, S_LOAD_B, S_EXEC: sel = LED_DIN;
            S_SHOW:                     sel = LED_RESULT;
            default:                    sel = LED_BLANK;
        endcase
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // Button front end
    // ------------------------------------------------------------------
    logic r_next_p0;
    logic r_next_p1;
    logic w_press;

    // Two-flop synchronizer for the asynchronous button; clear parks it released.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_next_p0 <= 1'b1;
            r_next_p1 <= 1'b1;
        end else begin
            r_next_p0 <= next;
            r_next_p1 <= r_next_p0;
        end
    end

`ifdef OP_SEQUENCER_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] r_db_cnt;
    logic        r_db_level;
    logic        r_db_press;

    // Accept a new level only after it has differed from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles; any reversal restarts the count.
    // A press is a one-cycle pulse when the accepted level falls.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_db_cnt   <= 16'd0;
            r_db_level <= 1'b1;
            r_db_press <= 1'b0;
        end else begin
            r_db_press <= 1'b0;
            if (r_next_p1 != r_db_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db_cnt   <= 16'd0;
                    r_db_level <= r_next_p1;
                    r_db_press <= r_db_level & ~r_next_p1;
                end else begin
                    r_db_cnt <= r_db_cnt + 16'd1;
                end
            end else begin
                r_db_cnt <= 16'd0;
            end
        end
    end

    assign w_press = r_db_press;
`else
    logic r_next_p2;

    // Previous synchronized level, for falling-edge detection.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_next_p2 <= 1'b1;
        end else begin
            r_next_p2 <= r_next_p1;
        end
    end

    // Every synchronized 1->0 transition is a press; release produces nothing.
    assign w_press = r_next_p2 & ~r_next_p1;

    // The debounce length has no role without the debouncer; keep it referenced.
    logic [15:0] w_unused_db_cfg;
    assign w_unused_db_cfg = 16'(DEBOUNCE_CYCLES);
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [3:0] r_exec_cnt;
    logic [2:0] r_ms_q;
    logic       r_we;
    logic       r_w1;
    logic       r_alu_en;
    logic [1:0] r_led_sel;
    logic       r_done;
    logic [3:0] r_cs_out;

    logic [2:0] w_state_nxt;
    logic [3:0] w_exec_cnt_nxt;
    logic [2:0] w_ms_q_nxt;
    logic       w_we_nxt;
    logic       w_w1_nxt;

    // Next-state, write-strobe and operation-latch decisions. Presses in EXEC
    // fall through unused, so they are dropped rather than queued.
    always_comb begin
        w_state_nxt    = r_state;
        w_exec_cnt_nxt = r_exec_cnt;
        w_ms_q_nxt     = r_ms_q;
        w_we_nxt       = 1'b0;
        w_w1_nxt       = r_w1;

        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_ms_q_nxt  = MS;
                    w_state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (w_press) begin
                    w_we_nxt = 1'b1;
                    w_w1_nxt = 1'b0;
                    if (r_ms_q >= FIRST_UNARY_OP) begin
                        w_state_nxt    = S_EXEC;
                        w_exec_cnt_nxt = EXEC_LOAD;
                    end else begin
                        w_state_nxt = S_LOAD_B;
                    end
                end
            end
            S_LOAD_B: begin
                if (w_press) begin
                    w_we_nxt       = 1'b1;
                    w_w1_nxt       = 1'b1;
                    w_state_nxt    = S_EXEC;
                    w_exec_cnt_nxt = EXEC_LOAD;
                end
            end
            S_EXEC: begin
                if (r_exec_cnt == 4'd0) begin
                    w_state_nxt = S_SHOW;
                end else begin
                    w_exec_cnt_nxt = r_exec_cnt - 4'd1;
                end
            end
            S_SHOW: begin
                if (w_press) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                // Unused encodings recover to IDLE on the next edge.
                w_state_nxt    = S_IDLE;
                w_exec_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State register with outputs decoded from the next state, so every
    // output is a flop and changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= S_IDLE;
            r_exec_cnt <= 4'd0;
            r_ms_q     <= 3'd0;
            r_we       <= 1'b0;
            r_w1       <= 1'b0;
            r_alu_en   <= 1'b0;
            r_led_sel  <= LED_BLANK;
            r_done     <= 1'b0;
            r_cs_out   <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_exec_cnt <= w_exec_cnt_nxt;
            r_ms_q     <= w_ms_q_nxt;
            r_we       <= w_we_nxt;
            r_w1       <= w_w1_nxt;
            r_alu_en   <= (w_state_nxt == S_EXEC);
            r_led_sel  <= led_for_state(w_state_nxt);
            r_done     <= (w_state_nxt == S_SHOW);
            r_cs_out   <= {1'b0, w_state_nxt};
        end
    end

    assign ms_q    = r_ms_q;
    assign we      = r_we;
    assign w1      = r_w1;
    assign alu_en  = r_alu_en;
    assign led_sel = r_led_sel;
    assign done    = r_done;
    assign cs_out  = r_cs_out;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: a per-cycle vector table for the binary and
// unary walks, plus hand-written sequences for held presses, clear during
// EXEC and a long EXEC window. A second instance uses EXEC_CYCLES=15.
module tb_op_sequencer;

    logic       clk;
    logic       clear;
    logic       next;
    logic [2:0] MS;

    logic [2:0] o_ms_q;
    logic       o_we;
    logic       o_w1;
    logic       o_alu;
    logic [1:0] o_led;
    logic       o_done;
    logic [3:0] o_cs;

    logic [2:0] o15_ms_q;
    logic       o15_we;
    logic       o15_w1;
    logic       o15_alu;
    logic [1:0] o15_led;
    logic       o15_done;
    logic [3:0] o15_cs;

    int n_checks;
    int n_errors;

    op_sequencer #(.EXEC_CYCLES(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .clear(clear), .next(next), .MS(MS),
        .ms_q(o_ms_q), .we(o_we), .w1(o_w1), .alu_en(o_alu),
        .led_sel(o_led), .done(o_done), .cs_out(o_cs)
    );

    op_sequencer #(.EXEC_CYCLES(15), .DEBOUNCE_CYCLES(16)) dut15 (
        .clk(clk), .clear(clear), .next(next), .MS(MS),
        .ms_q(o15_ms_q), .we(o15_we), .w1(o15_w1), .alu_en(o15_alu),
        .led_sel(o15_led), .done(o15_done), .cs_out(o15_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        next  = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

`ifndef OP_SEQUENCER_DEBOUNCE_EN
    // Two low samples then release; the state change is visible on return.
    task automatic press();
        next = 1'b0;
        tick();
        tick();
        next = 1'b1;
        tick();
    endtask

    typedef struct {
        logic       clr;
        logic       nxt;
        logic [2:0] ms;
        logic [3:0] cs;
        logic       we;
        logic       w1;
        logic       alu;
        logic [1:0] led;
        logic       done;
        logic [2:0] msq;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];
`endif

    initial begin
        int changes;
        int we_cnt;
        int alu_cnt;
        bit shown;
        logic [3:0] prev_cs;

        n_checks = 0;
        n_errors = 0;
        clear = 1'b1;
        next  = 1'b1;
        MS    = 3'd0;

`ifndef OP_SEQUENCER_DEBOUNCE_EN
        // inputs: clr, next, MS | expected after the edge: cs, we, w1, alu, led, done, ms_q
        // Binary op MS=3: presses sampled at 2, 6, 10, 15 take effect two edges later.
        tbl[0]  = '{1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0};
        tbl[4]  = '{1'b0, 1'b1, 3'd3, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[5]  = '{1'b0, 1'b1, 3'd3, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[6]  = '{1'b0, 1'b0, 3'd3, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[7]  = '{1'b0, 1'b0, 3'd3, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[8]  = '{1'b0, 1'b1, 3'd3, 4'd2, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[9]  = '{1'b0, 1'b1, 3'd3, 4'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[10] = '{1'b0, 1'b0, 3'd3, 4'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[11] = '{1'b0, 1'b0, 3'd3, 4'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 3'd3};
        tbl[12] = '{1'b0, 1'b1, 3'd3, 4'd3, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 3'd3};
        tbl[13] = '{1'b0, 1'b1, 3'd3, 4'd3, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 3'd3};
        tbl[14] = '{1'b0, 1'b1, 3'd3, 4'd4, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 3'd3};
        tbl[15] = '{1'b0, 1'b0, 3'd3, 4'd4, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 3'd3};
        tbl[16] = '{1'b0, 1'b0, 3'd3, 4'd4, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 3'd3};
        tbl[17] = '{1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd3};
        // Unary op MS=7; MS moves to 5 while in LOAD_A and must not reach ms_q.
        tbl[18] = '{1'b0, 1'b1, 3'd7, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd3};
        tbl[19] = '{1'b0, 1'b0, 3'd7, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd3};
        tbl[20] = '{1'b0, 1'b0, 3'd7, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd3};
        tbl[21] = '{1'b0, 1'b1, 3'd7, 4'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd7};
        tbl[22] = '{1'b0, 1'b0, 3'd5, 4'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd7};
        tbl[23] = '{1'b0, 1'b0, 3'd5, 4'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 3'd7};
        tbl[24] = '{1'b0, 1'b1, 3'd5, 4'd3, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 3'd7};
        tbl[25] = '{1'b0, 1'b1, 3'd5, 4'd3, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 3'd7};
        tbl[26] = '{1'b0, 1'b1, 3'd5, 4'd4, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 3'd7};
        tbl[27] = '{1'b0, 1'b0, 3'd5, 4'd4, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 3'd7};
        tbl[28] = '{1'b0, 1'b0, 3'd5, 4'd4, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 3'd7};
        tbl[29] = '{1'b0, 1'b1, 3'd5, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd7};

        for (int i = 0; i < NVEC; i++) begin
            clear = tbl[i].clr;
            next  = tbl[i].nxt;
            MS    = tbl[i].ms;
            tick();
            chk($sformatf("v%0d_cs", i),   int'(o_cs),   int'(tbl[i].cs));
            chk($sformatf("v%0d_we", i),   int'(o_we),   int'(tbl[i].we));
            chk($sformatf("v%0d_w1", i),   int'(o_w1),   int'(tbl[i].w1));
            chk($sformatf("v%0d_alu", i),  int'(o_alu),  int'(tbl[i].alu));
            chk($sformatf("v%0d_led", i),  int'(o_led),  int'(tbl[i].led));
            chk($sformatf("v%0d_done", i), int'(o_done), int'(tbl[i].done));
            chk($sformatf("v%0d_msq", i),  int'(o_ms_q), int'(tbl[i].msq));
        end

        // Button held low for 100 cycles in IDLE: one transition, no writes.
        do_clear();
        MS = 3'd2;
        next = 1'b0;
        changes = 0;
        we_cnt = 0;
        prev_cs = o_cs;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (o_cs != prev_cs) changes++;
            if (o_we) we_cnt++;
            prev_cs = o_cs;
        end
        chk("hold_changes", changes, 1);
        chk("hold_cs", int'(o_cs), 1);
        chk("hold_we_cnt", we_cnt, 0);
        chk("hold_msq", int'(o_ms_q), 2);
        next = 1'b1;
        repeat (4) tick();
        chk("hold_release_cs", int'(o_cs), 1);

        // Clear in the second EXEC cycle, with a press riding on the clear.
        do_clear();
        MS = 3'd6;
        press();
        chk("clr_loada_cs", int'(o_cs), 1);
        press();
        chk("clr_exec_cs", int'(o_cs), 3);
        chk("clr_exec_we", int'(o_we), 1);
        chk("clr_exec_w1", int'(o_w1), 0);
        tick();
        chk("clr_exec2_cs", int'(o_cs), 3);
        chk("clr_exec2_alu", int'(o_alu), 1);
        clear = 1'b1;
        next  = 1'b0;
        tick();
        chk("clr_cs", int'(o_cs), 0);
        chk("clr_alu", int'(o_alu), 0);
        chk("clr_done", int'(o_done), 0);
        chk("clr_msq", int'(o_ms_q), 0);
        chk("clr_led", int'(o_led), 0);
        chk("clr_we", int'(o_we), 0);
        tick();
        clear = 1'b0;
        next  = 1'b1;
        repeat (6) tick();
        chk("clr_press_lost_cs", int'(o_cs), 0);

        // EXEC_CYCLES=15 instance: a press inside EXEC is discarded.
        do_clear();
        MS = 3'd0;
        press();
        press();
        chk("x15_loadb_cs", int'(o15_cs), 2);
        press();
        chk("x15_exec_cs", int'(o15_cs), 3);
        alu_cnt = o15_alu ? 1 : 0;
        shown = 1'b0;
        next = 1'b0;
        for (int k = 0; k < 40 && !shown; k++) begin
            if (k == 2) next = 1'b1;
            tick();
            if (o15_alu) alu_cnt++;
            if (o15_cs == 4'd4) shown = 1'b1;
        end
        next = 1'b1;
        chk("x15_reached_show", int'(shown), 1);
        chk("x15_alu_cycles", alu_cnt, 15);
        chk("x15_done", int'(o15_done), 1);
        repeat (20) tick();
        chk("x15_stays_show", int'(o15_cs), 4);
        press();
        chk("x15_back_idle", int'(o15_cs), 0);
`else
        // Reset state.
        do_clear();
        chk("db_reset_cs", int'(o_cs), 0);
        chk("db_reset_led", int'(o_led), 0);

        // 10-cycle glitch is shorter than the debounce window.
        next = 1'b0;
        repeat (10) tick();
        next = 1'b1;
        repeat (30) tick();
        chk("db_glitch_cs", int'(o_cs), 0);

        // 20-cycle press: first sampled at edge N, state moves at edge N+18.
        MS = 3'd4;
        next = 1'b0;
        repeat (18) tick();
        chk("db_lat_before_cs", int'(o_cs), 0);
        tick();
        chk("db_lat_at_cs", int'(o_cs), 1);
        chk("db_lat_msq", int'(o_ms_q), 4);
        tick();
        next = 1'b1;
        repeat (40) tick();
        chk("db_release_cs", int'(o_cs), 1);

        // Chatter then a steady press gives exactly one transition.
        do_clear();
        changes = 0;
        prev_cs = o_cs;
        for (int r = 0; r < 5; r++) begin
            next = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (o_cs != prev_cs) changes++;
                prev_cs = o_cs;
            end
            next = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (o_cs != prev_cs) changes++;
                prev_cs = o_cs;
            end
        end
        next = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (o_cs != prev_cs) changes++;
            prev_cs = o_cs;
        end
        chk("db_chatter_changes", changes, 1);
        chk("db_chatter_cs", int'(o_cs), 1);
        next = 1'b1;
        repeat (40) tick();
        chk("db_chatter_release_cs", int'(o_cs), 1);
        we_cnt = 0;
        alu_cnt = 0;
        shown = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Operand-entry and execution sequencer for the calculator datapath. It turns the `next` push-button into a fixed sequence: operand A write, operand B write (skipped for unary ops), a timed ALU execute window, then result display. It replaces ad-hoc button handling between the front panel and the register-file/ALU datapath. It also supplies register-write strobes, display select, a done flag and a state code for the status seven-segment digit.

## Interface
Parameters:
- `EXEC_CYCLES`, default 2: cycles `alu_en` is held in EXEC (range 1..15).
- `DEBOUNCE_CYCLES`, default 16: stable-level count before a press/release is accepted (used only with the debounce macro; range 1..65535).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `clear`  in  1  reset; synchronous, active-high; highest priority.
- `next`  in  1  raw push-button, active-low (pressed = 0); asynchronous to `clk`.
- `MS`  in  3  operation select from switches; sampled only on accepted press in IDLE.
- `ms_q`  out  3  latched operation, held stable until next IDLE accept.
- `we`  out  1  register-file write strobe, one-cycle pulse.
- `w1`  out  1  write address: 0 = operand A, 1 = operand B; valid while `we`=1, else holds last value.
- `alu_en`  out  1  ALU execute enable, high throughout EXEC.
- `led_sel`  out  2  display source: 00 blank, 01 live `Din` digits, 10 ALU result.
- `done`  out  1  result valid, high throughout SHOW.
- `cs_out`  out  4  current state code for the status digit.

## Operation
- Front end: `next` passes through a 2-flop synchronizer. A third flop holds the previous synchronized value. An accepted press is a one-cycle internal pulse on a synchronized 1→0 transition. Holding the button produces exactly one press; release generates nothing.
- States and `cs_out` codes: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, SHOW=4. Codes 5–15 unused; any unreachable encoding returns to IDLE on the next edge.
- IDLE: `led_sel`=00. On press: `ms_q`←`MS`, go to LOAD_A.
- LOAD_A: `led_sel`=01. On press: `we`=1, `w1`=0 for one cycle. Go to LOAD_B if `ms_q`≤5 (binary); go to EXEC if `ms_q`∈{6,7} (unary).
- LOAD_B: `led_sel`=01. On press: `we`=1, `w1`=1 for one cycle, go to EXEC.
- EXEC: `alu_en`=1, `led_sel`=01. A 4-bit counter loads `EXEC_CYCLES`-1 on entry, decrements each cycle and exits to SHOW after it reads 0. Presses during EXEC are discarded, not queued.
- SHOW: `done`=1, `led_sel`=10. On press: go to IDLE.
- `MS` changes outside IDLE accept have no effect on `ms_q`.
- `clear` (any state, including mid-EXEC or during a `we` pulse): next edge forces IDLE and clears the counter and synchronizer flops to the released level (1). Outputs take reset values. A press coincident with `clear` is lost.
- Reset values: `ms_q`=000, `we`=0, `w1`=0, `alu_en`=0, `led_sel`=00, `done`=0, `cs_out`=0.

## Timing
- All outputs are registered; none depends combinationally on inputs.
- Press latency, no debounce: if `next` is first sampled low at edge N, the state change and `we` pulse appear after edge N+2. `we` drops after edge N+3.
- EXEC spans exactly `EXEC_CYCLES` cycles of `alu_en`=1. `done` rises on the edge that drops `alu_en`.
- Minimum button-to-button spacing: one press per state. Back-to-back presses on consecutive cycles are impossible by construction, since a press needs a release in between.

## Configuration
- `OP_SEQUENCER_DEBOUNCE_EN` defined:
  - After synchronization, a 16-bit counter requires the level to differ from the accepted level for `DEBOUNCE_CYCLES` consecutive cycles before the accepted level changes. Any reversal restarts the count.
  - A press pulse is issued when the accepted level goes 1→0.
  - Latency becomes edge N+2+`DEBOUNCE_CYCLES`.
  - Glitches shorter than `DEBOUNCE_CYCLES` are ignored.
- Not defined: no counter; behaviour is the plain synchronizer + edge detect above. Every synchronized 1→0 transition is a press.

## Test plan
- Binary op, no debounce, `EXEC_CYCLES`=2, `MS`=3:
  - Four presses give `cs_out` 0→1→2→3→4→0.
  - `we` pulses twice, with `w1`=0 then 1.
  - `alu_en` is high exactly 2 cycles; `done`=1 in SHOW; `ms_q`=3.
- Unary op `MS`=7: the LOAD_A press gives one `we` with `w1`=0, then `cs_out` goes 1→3 directly; no second `we`.
- Hold `next` low 100 cycles in IDLE: exactly one transition to LOAD_A. Change `MS` to 5 while in LOAD_A: `ms_q` stays at its latched value.
- `clear` asserted during the 2nd EXEC cycle: after the next edge `cs_out`=0, `alu_en`=0, `done`=0 and `ms_q`=0. A press coincident with `clear` leaves the block in IDLE.
- With `OP_SEQUENCER_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=16:
  - A 10-cycle low glitch gives no transition.
  - A 20-cycle low press moves IDLE→LOAD_A at edge N+18.
  - Chatter (alternating 3 low / 3 high for 30 cycles, then steady low) gives exactly one press.
- Press during EXEC with `EXEC_CYCLES`=15: ignored. The block still reaches SHOW after 15 cycles and stays there until a fresh press.
